// File: rtl/load_store_unit_if.sv
// Request/response handshake between the execute stage and the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V byte/half/word loads and stores onto a word-addressed memory with
// combinational read; sub-word stores merge into the read word in one cycle.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  load_store_unit_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [31:0]           mem_read_data,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [31:0]           mem_write_data,
  output logic                  mem_wen
);
  localparam int DATA_W = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  accept;
  logic                  req_bad;
  logic                  unused_addr;

  function automatic logic is_err(input logic we, input logic [2:0] f3,
                                  input logic [1:0] a);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a != 2'b00;
      3'b100:  return we;
      3'b101:  return we | a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] w,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] w,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] off);
    logic [DATA_W-1:0] m;
    m = w;
    case (f3[1:0])
      2'b00:   m[8*off +: 8] = wd[7:0];
      2'b01:   m[16*off[1] +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  assign unused_addr    = ^bus.req_addr[31:ADDR_WIDTH+2];
  assign bus.req_ready  = (state_q == IDLE) & rst_n;
  assign accept         = bus.req_valid & bus.req_ready;
  assign req_bad        = is_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign mem_read_addr  = idx_q;
  assign mem_write_addr = idx_q;
  assign mem_wen        = (state_q == ACCESS) & we_q;
  assign mem_write_data = store_merge(mem_read_data, wdata_q, funct3_q, off_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_bad ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q <= bus.req_addr[ADDR_WIDTH+1:2];
        err_q <= req_bad;
        if (req_bad) rdata_q <= '0;
      end
      if (state_q == ACCESS)
        rdata_q <= we_q ? '0 : load_ext(mem_read_data, funct3_q, off_q);
    end
  end

  // request payload, only meaningful after an accept
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      off_q    <= bus.req_addr[1:0];
      wdata_q  <= bus.req_wdata;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word-addressed memory.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] mem_read_addr, mem_write_addr;
  logic [31:0] mem_read_data, mem_write_data;
  logic        mem_wen;
  logic [31:0] mem [0:4095];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] r_rdata;
  logic        r_err;
  int          r_wcnt;
  logic [11:0] r_waddr;
  int          r_lat;
  logic [31:0] held;

  load_store_unit_if bus ();

  load_store_unit #(.ADDR_WIDTH(12)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_wen       (mem_wen)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_read_addr];
  always @(posedge clk) if (mem_wen) mem[mem_write_addr] <= mem_write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // issue one request with resp_ready=1 and collect the response
  task automatic request(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    r_lat = 1; r_wcnt = 0; r_waddr = 'x;
    while (!bus.resp_valid && r_lat < 10) begin
      if (mem_wen) begin r_wcnt++; r_waddr = mem_write_addr; end
      @(posedge clk); #1;
      r_lat++;
    end
    r_rdata = bus.resp_rdata;
    r_err   = bus.resp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;

    // reset state
    #3;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_read_addr", 32'(mem_read_addr), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_req_ready", 32'(bus.req_ready), 32'd1);

    // reset in the middle of a store's ACCESS cycle
    request(1'b1, 3'b010, 32'h30, 32'h01234567);
    chk("pre_mem12", mem[12], 32'h01234567);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h30; bus.req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("acc_wen", 32'(mem_wen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_wen", 32'(mem_wen), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_mem12", mem[12], 32'h01234567);
    chk("midrst_req_ready_after", 32'(bus.req_ready), 32'd1);

    // word store/load
    request(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_wcnt", 32'(r_wcnt), 32'd1);
    chk("sw_waddr", 32'(r_waddr), 32'd4);
    chk("sw_lat", 32'(r_lat), 32'd2);
    chk("sw_rdata", r_rdata, 32'd0);
    chk("sw_err", 32'(r_err), 32'd0);
    request(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_rdata", r_rdata, 32'hDEADBEEF);
    chk("lw_lat", 32'(r_lat), 32'd2);
    chk("lw_wcnt", 32'(r_wcnt), 32'd0);

    // byte lanes
    request(1'b1, 3'b010, 32'h04, 32'h11223344);
    request(1'b1, 3'b000, 32'h07, 32'h123456AA);
    chk("sb_mem1", mem[1], 32'hAA223344);
    chk("sb_rdata", r_rdata, 32'd0);
    request(1'b0, 3'b000, 32'h07, 32'h0);
    chk("lb_07", r_rdata, 32'hFFFFFFAA);
    request(1'b0, 3'b100, 32'h07, 32'h0);
    chk("lbu_07", r_rdata, 32'h000000AA);
    request(1'b0, 3'b000, 32'h04, 32'h0);
    chk("lb_04", r_rdata, 32'h00000044);
    request(1'b0, 3'b100, 32'h05, 32'h0);
    chk("lbu_05", r_rdata, 32'h00000033);

    // halfword lanes
    request(1'b1, 3'b010, 32'h20, 32'h0);
    request(1'b1, 3'b001, 32'h22, 32'hFFFF8001);
    chk("sh_mem8", mem[8], 32'h80010000);
    request(1'b0, 3'b001, 32'h22, 32'h0);
    chk("lh_22", r_rdata, 32'hFFFF8001);
    request(1'b0, 3'b101, 32'h22, 32'h0);
    chk("lhu_22", r_rdata, 32'h00008001);
    request(1'b0, 3'b001, 32'h04, 32'h0);
    chk("lh_04", r_rdata, 32'h00003344);

    // error responses
    request(1'b0, 3'b010, 32'h11, 32'h0);
    chk("e_lw11_err", 32'(r_err), 32'd1);
    chk("e_lw11_rdata", r_rdata, 32'd0);
    chk("e_lw11_lat", 32'(r_lat), 32'd1);
    chk("e_lw11_wcnt", 32'(r_wcnt), 32'd0);
    request(1'b1, 3'b001, 32'h21, 32'hFFFFFFFF);
    chk("e_sh21_err", 32'(r_err), 32'd1);
    chk("e_sh21_lat", 32'(r_lat), 32'd1);
    chk("e_sh21_wcnt", 32'(r_wcnt), 32'd0);
    chk("e_sh21_mem8", mem[8], 32'h80010000);
    request(1'b1, 3'b100, 32'h10, 32'h0);
    chk("e_st100_err", 32'(r_err), 32'd1);
    chk("e_st100_lat", 32'(r_lat), 32'd1);
    chk("e_st100_mem4", mem[4], 32'hDEADBEEF);
    request(1'b0, 3'b011, 32'h10, 32'h0);
    chk("e_ld011_err", 32'(r_err), 32'd1);
    chk("e_ld011_rdata", r_rdata, 32'd0);
    chk("e_ld011_lat", 32'(r_lat), 32'd1);
    request(1'b0, 3'b010, 32'h10, 32'h0);
    chk("after_err_clears", 32'(r_err), 32'd0);

    // response back-pressure with a competing request held valid
    bus.resp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_we = 1'b1; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    held = bus.resp_rdata;
    chk("bp_first_rdata", held, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_rdata_stable", bus.resp_rdata, held);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_no_wen", 32'(mem_wen), 32'd0);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_mem4", mem[4], 32'hDEADBEEF);

    // address wrap
    request(1'b1, 3'b010, 32'h4000, 32'h5A5A5A5A);
    chk("wrap_waddr", 32'(r_waddr), 32'd0);
    request(1'b0, 3'b010, 32'h0, 32'h0);
    chk("wrap_lw0", r_rdata, 32'h5A5A5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
